// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller and the core
// datapath's EX-stage operand mux selects.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Register index width carried in a pipeline slot; matches RV32I's 32 registers.
  localparam int SLOT_AW = 5;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               regwrite;
    logic               memread;
  } slot_t;

  // A slot produces a forwardable result; x0 is hard-wired and never forwarded.
  function automatic logic slot_writing(slot_t s);
    return s.valid && s.regwrite && (s.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding comparator: picks the youngest in-flight producer of rs.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [SLOT_AW-1:0] rs_i,
  input  logic               use_rs_i,
  input  slot_t              mem_i,
  input  slot_t              wb_i,
  output logic [1:0]         sel_o
);

  // NOTE: assigning a default first in always_comb guarantees no latch is inferred.
  always_comb begin
    sel_o = FWD_RF;
    if (use_rs_i && slot_writing(mem_i) && (mem_i.rd == rs_i)) begin
      sel_o = FWD_MEM;
    end else if (use_rs_i && slot_writing(wb_i) && (wb_i.rd == rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: tracks EX/MEM/WB
// destination state, drives operand mux selects, and inserts load-use stalls.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = SLOT_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  slot_t              ex_q, ex_d, mem_q, wb_q;
  logic [REG_AW-1:0]  ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic               ex_use_rs1_q, ex_use_rs1_d, ex_use_rs2_q, ex_use_rs2_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               rs1_hit, rs2_hit;

  // Load-use: the ID instruction needs a value the load in EX has not fetched yet.
  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_q.rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_q.rd);
  assign stall   = !flush && id_valid && ex_q.valid && ex_q.memread &&
                   (ex_q.rd != '0) && (rs1_hit || rs2_hit);
  assign bubble  = stall || flush;

  // A bubble clears the use flags too, so an empty EX slot never requests forwarding.
  always_comb begin
    ex_d         = '0;
    ex_rs1_d     = '0;
    ex_rs2_d     = '0;
    ex_use_rs1_d = 1'b0;
    ex_use_rs2_d = 1'b0;
    if (id_valid && !bubble) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_use_rs1_d  = id_use_rs1;
      ex_use_rs2_d  = id_use_rs2;
    end
  end

  assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, letting MEM <- EX and WB <- MEM shift correctly in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_use_rs1_q <= 1'b0;
      ex_use_rs2_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= ex_q;
      wb_q         <= mem_q;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_use_rs1_q <= ex_use_rs1_d;
      ex_use_rs2_q <= ex_use_rs2_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

  fwd_select u_fwd_a (
    .rs_i     (ex_rs1_q),
    .use_rs_i (ex_use_rs1_q),
    .mem_i    (mem_q),
    .wb_i     (wb_q),
    .sel_o    (fwd_a)
  );

  fwd_select u_fwd_b (
    .rs_i     (ex_rs2_q),
    .use_rs_i (ex_use_rs2_q),
    .mem_i    (mem_q),
    .wb_i     (wb_q),
    .sel_o    (fwd_b)
  );

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed pipeline scenarios plus a
// randomized run against an instruction-history reference model (CNT_W=4).
module tb_hazard_fwd_unit;

  localparam int AW     = 5;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          use1;
    logic          use2;
    logic          regwrite;
    logic          memread;
  } instr_t;

  logic          clk;
  logic          rst;
  logic          flush;
  instr_t        cur;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall, bubble;
  logic [CW-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pipe[0] is the instruction in EX, pipe[1] MEM, pipe[2] WB.
  instr_t pipe[$];
  int     m_cnt;

  hazard_fwd_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (cur.valid),
    .id_rs1     (cur.rs1),
    .id_rs2     (cur.rs2),
    .id_use_rs1 (cur.use1),
    .id_use_rs2 (cur.use2),
    .id_rd      (cur.rd),
    .id_regwrite(cur.regwrite),
    .id_memread (cur.memread),
    .flush      (flush),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .stall      (stall),
    .bubble     (bubble),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t mk(int rd, int rs1, int rs2, bit u1, bit u2, bit rw, bit mr);
    instr_t t;
    t.valid = 1'b1; t.rd = AW'(rd); t.rs1 = AW'(rs1); t.rs2 = AW'(rs2);
    t.use1 = u1; t.use2 = u2; t.regwrite = rw; t.memread = mr;
    return t;
  endfunction

  function automatic bit m_writes(instr_t p);
    return p.valid && p.regwrite && (p.rd != 0);
  endfunction

  // Youngest older instruction that writes rs supplies the operand.
  function automatic logic [1:0] m_fwd(logic [AW-1:0] rs, logic use_rs);
    if (!use_rs) return 2'b00;
    for (int age = 1; age <= 2; age++)
      if (m_writes(pipe[age]) && pipe[age].rd == rs) return (age == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    instr_t e;
    e = pipe[0];
    if (flush || !cur.valid || !e.valid || !e.memread || e.rd == 0) return 1'b0;
    return (cur.use1 && cur.rs1 == e.rd) || (cur.use2 && cur.rs2 == e.rd);
  endfunction

  task automatic settle();
    #3;
  endtask

  // Clock edge plus model update; returns 1 ns after the edge, ready for new inputs.
  task automatic advance();
    instr_t entering;
    bit     st;
    st       = m_stall();
    entering = (cur.valid && !st && !flush) ? cur : '0;
    @(posedge clk);
    if (rst) begin
      pipe = '{'0, '0, '0};
      m_cnt = 0;
    end else begin
      pipe.push_front(entering);
      void'(pipe.pop_back());
      if (st && m_cnt < CNTMAX) m_cnt++;
    end
    #1;
  endtask

  task automatic nop();
    cur = '0; flush = 1'b0;
  endtask

  task automatic drain();
    nop();
    repeat (3) advance();
  endtask

  task automatic test_reset();
    rst = 1'b1; nop();
    repeat (2) advance();
    rst = 1'b0;
    cur = mk(5, 5, 5, 1, 1, 1, 0);
    settle();
    n_vec++; if (fwd_a !== 2'b00) begin n_err++; $display("FAIL reset_fwd_a got %b want 00", fwd_a); end
    n_vec++; if (fwd_b !== 2'b00) begin n_err++; $display("FAIL reset_fwd_b got %b want 00", fwd_b); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
    n_vec++; if (bubble !== 1'b0) begin n_err++; $display("FAIL reset_bubble got %b want 0", bubble); end
    n_vec++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    advance();
    drain();
  endtask

  task automatic test_mem_fwd();
    cur = mk(5, 1, 2, 1, 1, 1, 0);            // add x5,x1,x2
    advance();
    cur = mk(6, 5, 1, 1, 1, 1, 0);            // sub x6,x5,x1
    settle();
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mem_fwd_stall got %b want 0", stall); end
    advance();
    nop(); settle();
    n_vec++; if (fwd_a !== 2'b10) begin n_err++; $display("FAIL mem_fwd_a got %b want 10", fwd_a); end
    n_vec++; if (fwd_b !== 2'b00) begin n_err++; $display("FAIL mem_fwd_b got %b want 00", fwd_b); end
    drain();
  endtask

  task automatic test_wb_fwd();
    cur = mk(5, 1, 2, 1, 1, 1, 0); advance(); // add x5
    nop(); advance();
    cur = mk(7, 1, 5, 1, 1, 1, 0); advance(); // or x7,x1,x5
    nop(); settle();
    n_vec++; if (fwd_b !== 2'b01) begin n_err++; $display("FAIL wb_fwd_b got %b want 01", fwd_b); end
    n_vec++; if (fwd_a !== 2'b00) begin n_err++; $display("FAIL wb_fwd_a got %b want 00", fwd_a); end
    drain();
    cur = mk(5, 1, 2, 1, 1, 1, 0); advance(); // add x5
    cur = mk(5, 3, 4, 1, 1, 1, 0); advance(); // add x5
    cur = mk(8, 5, 5, 1, 1, 1, 0); advance(); // and x8,x5,x5
    nop(); settle();
    n_vec++; if (fwd_a !== 2'b10) begin n_err++; $display("FAIL prio_fwd_a got %b want 10", fwd_a); end
    n_vec++; if (fwd_b !== 2'b10) begin n_err++; $display("FAIL prio_fwd_b got %b want 10", fwd_b); end
    drain();
  endtask

  task automatic test_x0_use();
    cur = mk(0, 1, 0, 1, 0, 1, 0); advance(); // addi x0,x1,imm
    cur = mk(3, 0, 0, 1, 1, 1, 0); advance(); // add x3,x0,x0
    nop(); settle();
    n_vec++; if (fwd_a !== 2'b00) begin n_err++; $display("FAIL x0_fwd_a got %b want 00", fwd_a); end
    n_vec++; if (fwd_b !== 2'b00) begin n_err++; $display("FAIL x0_fwd_b got %b want 00", fwd_b); end
    drain();
    cur = mk(5, 0, 0, 0, 0, 1, 0); advance(); // lui x5
    cur = mk(9, 5, 0, 0, 0, 1, 0); advance(); // rs1=5 not read
    nop(); settle();
    n_vec++; if (fwd_a !== 2'b00) begin n_err++; $display("FAIL use_flag_fwd_a got %b want 00", fwd_a); end
    drain();
  endtask

  task automatic test_load_use();
    cur = mk(5, 1, 0, 1, 0, 1, 1);            // lw x5,0(x1)
    advance();
    cur = mk(6, 5, 2, 1, 1, 1, 0);            // add x6,x5,x2
    settle();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b want 1", stall); end
    n_vec++; if (bubble !== 1'b1) begin n_err++; $display("FAIL lu_bubble got %b want 1", bubble); end
    n_vec++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL lu_cnt_before got %0d want 0", stall_cnt); end
    advance();                                // consumer held in ID
    settle();
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_once got %b want 0", stall); end
    n_vec++; if (bubble !== 1'b0) begin n_err++; $display("FAIL lu_bubble_once got %b want 0", bubble); end
    n_vec++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL lu_cnt_after got %0d want 1", stall_cnt); end
    advance();
    nop(); settle();
    n_vec++; if (fwd_a !== 2'b01) begin n_err++; $display("FAIL lu_fwd_a got %b want 01", fwd_a); end
    n_vec++; if (fwd_b !== 2'b00) begin n_err++; $display("FAIL lu_fwd_b got %b want 00", fwd_b); end
    drain();
  endtask

  task automatic test_flush_stall();
    cur = mk(5, 1, 0, 1, 0, 1, 1); advance(); // lw x5
    cur = mk(6, 5, 2, 1, 1, 1, 0); flush = 1'b1;
    settle();
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL fl_stall got %b want 0", stall); end
    n_vec++; if (bubble !== 1'b1) begin n_err++; $display("FAIL fl_bubble got %b want 1", bubble); end
    advance();
    cur = mk(10, 6, 0, 1, 0, 1, 0);           // reads x6 of the squashed add
    flush = 1'b0; settle();
    n_vec++; if (stall_cnt !== CW'(m_cnt)) begin n_err++; $display("FAIL fl_cnt got %0d want %0d", stall_cnt, m_cnt); end
    advance();
    nop(); settle();
    n_vec++; if (fwd_a !== 2'b00) begin n_err++; $display("FAIL fl_ex_squashed got %b want 00", fwd_a); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    cur = mk(5, 1, 0, 1, 0, 1, 1); advance(); // lw x5
    cur = mk(6, 5, 2, 1, 1, 1, 0); rst = 1'b1;
    settle();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rs_stall_pre got %b want 1", stall); end
    advance();
    rst = 1'b0; settle();
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rs_stall got %b want 0", stall); end
    n_vec++; if (bubble !== 1'b0) begin n_err++; $display("FAIL rs_bubble got %b want 0", bubble); end
    n_vec++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_err++; $display("FAIL rs_fwd got %b want 0000", {fwd_a, fwd_b}); end
    n_vec++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL rs_cnt got %0d want 0", stall_cnt); end
    drain();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      cur = mk(5, 1, 0, 1, 0, 1, 1); advance();
      cur = mk(6, 2, 5, 1, 1, 1, 0); settle();
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL sat_stall[%0d] got %b want 1", i, stall); end
      advance();
      advance();
    end
    nop(); settle();
    n_vec++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_cnt got %0d want 15", stall_cnt); end
    drain();
  endtask

  task automatic test_random();
    logic [1:0] ea, eb;
    bit         es;
    for (int i = 0; i < 400; i++) begin
      cur.valid    = ($urandom_range(0, 9) != 0);
      cur.rd       = AW'($urandom_range(0, 3));
      cur.rs1      = AW'($urandom_range(0, 3));
      cur.rs2      = AW'($urandom_range(0, 3));
      cur.use1     = $urandom_range(0, 1);
      cur.use2     = $urandom_range(0, 1);
      cur.regwrite = ($urandom_range(0, 3) != 0);
      cur.memread  = ($urandom_range(0, 2) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      rst          = ($urandom_range(0, 49) == 0);
      settle();
      ea = m_fwd(pipe[0].rs1, pipe[0].use1);
      eb = m_fwd(pipe[0].rs2, pipe[0].use2);
      es = m_stall();
      n_vec++; if (fwd_a !== ea) begin n_err++; $display("FAIL rnd_fwd_a[%0d] got %b want %b", i, fwd_a, ea); end
      n_vec++; if (fwd_b !== eb) begin n_err++; $display("FAIL rnd_fwd_b[%0d] got %b want %b", i, fwd_b, eb); end
      n_vec++; if (stall !== es) begin n_err++; $display("FAIL rnd_stall[%0d] got %b want %b", i, stall, es); end
      n_vec++; if (bubble !== (es || flush)) begin n_err++; $display("FAIL rnd_bubble[%0d] got %b want %b", i, bubble, es || flush); end
      n_vec++; if (stall_cnt !== CW'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, stall_cnt, m_cnt); end
      advance();
    end
    rst = 1'b0;
    drain();
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    cur   = '0;
    pipe  = '{'0, '0, '0};
    m_cnt = 0;
    test_reset();
    test_mem_fwd();
    test_wb_fwd();
    test_x0_use();
    test_load_use();
    test_flush_stall();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Pipeline hazard and forwarding controller for the 5-stage RV32I core. It tracks destination-register state of the ID/EX, EX/MEM and MEM/WB slots internally. From that state it generates the 2-bit select codes for the two EX-stage operand Mux_3_by_1 instances. It also detects load-use hazards and issues a one-cycle stall plus bubble, and maintains a saturating stall counter for performance debug.

## Interface
- `REG_AW`, default 5: register index width.
- `CNT_W`, default 32: stall counter width.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs1`, `id_rs2`  in  REG_AW  source indices of the ID instruction.
- `id_use_rs1`, `id_use_rs2`  in  1  ID instruction actually reads rs1/rs2.
- `id_rd`  in  REG_AW  destination index of the ID instruction.
- `id_regwrite`  in  1  ID instruction writes rd.
- `id_memread`  in  1  ID instruction is a load.
- `flush`  in  1  branch/jump taken in EX; squash IF and ID.
- `fwd_a`, `fwd_b`  out  2  EX operand mux selects: 00 = register file, 01 = WB result, 10 = MEM ALU result; 11 never driven.
- `stall`  out  1  hold PC and IF/ID register this cycle.
- `bubble`  out  1  load NOP into ID/EX at the next edge.
- `stall_cnt`  out  CNT_W  number of cycles with `stall`=1, saturating.

## Operation
- **Internal slots.** EX, MEM and WB slots each hold {valid, rd, regwrite, memread}. The EX slot additionally holds {rs1, rs2, use_rs1, use_rs2}.
- **Advance, every edge:**
  - WB ← MEM.
  - MEM ← EX.
  - EX ← ID fields when `id_valid` && !`stall` && !`flush`; otherwise EX ← bubble (valid=0, regwrite=0, memread=0).
- **A slot is "writing"** when valid && regwrite && rd != 0. Register x0 is never forwarded.
- **fwd_a (fwd_b is identical, using rs2/use_rs2):**
  - 10 if EX.use_rs1 && MEM writing && MEM.rd == EX.rs1.
  - else 01 if EX.use_rs1 && WB writing && WB.rd == EX.rs1.
  - else 00.
  - MEM has priority over WB, so the youngest producer wins.
- **Load-use hazard:** `stall` = !`flush` && `id_valid` && EX.valid && EX.memread && EX.rd != 0 && ((`id_use_rs1` && `id_rs1` == EX.rd) || (`id_use_rs2` && `id_rs2` == EX.rd)).
- `bubble` = `stall` || `flush`.
- **Flush has priority over stall.** The squashed ID instruction never stalls.
- **After one stall cycle** the load is in MEM. The dependent instruction enters EX and resolves through `fwd`=01 when the load reaches WB one cycle later. Wait, re-derive: the load is in MEM when the consumer is in ID, and in WB when the consumer is in EX. So load data always comes via `fwd`=01, never 10.
- **No MEM-slot memread forwarding check is needed.** The stall guarantees that a load is never in MEM while its consumer is in EX.
- **stall_cnt** increments on each edge where `stall`=1. It holds at all-ones (2^CNT_W−1) and never wraps.
- **Reset:** all slots invalid, `fwd_a`=`fwd_b`=00, `stall`=0, `bubble`=0, `stall_cnt`=0.
  - Reset asserted mid-stall clears everything at that edge.
  - The first cycle after reset has no forwarding and no stall.

## Timing
- `fwd_a`/`fwd_b` are combinational from registered slot state only. There is no path from the `id_*` inputs, and they are valid early in the cycle.
- `stall` and `bubble` are combinational from the `id_*` inputs, `flush` and the EX slot. They are same-cycle outputs with zero latency.
- Slot state has a 1-cycle latency per stage. An instruction presented in ID at cycle n (not stalled) is the EX slot in cycle n+1, MEM in n+2, and WB in n+3.
- A load-use pair causes exactly 1 stall cycle. Back-to-back loads feeding each other stall 1 cycle per dependency.
- Simultaneous `flush` and hazard: `stall`=0, `bubble`=1, and `stall_cnt` does not increment.

## Structure
- Shared package `hazard_pkg`:
  - Select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10. The core datapath uses the same constants on the Mux_3_by_1 selects.
  - A stage-slot struct typedef {valid, rd, regwrite, memread}.
- One sub-module, `fwd_select`: a per-operand comparator taking {rs, use_rs, MEM slot, WB slot} and returning the 2-bit select. It is instantiated twice.
- Slot registers and stall logic live in the top module.

## Test plan
- **MEM forward:** issue `add x5,…` then `sub x6,x5,x1` on consecutive cycles. When sub is in EX, require `fwd_a`=10 and `fwd_b`=00, with no stall.
- **WB forward and priority:**
  - `add x5` / nop / `or x7,x1,x5` → `fwd_b`=01.
  - `add x5` / `add x5` / `and x8,x5,x5` → `fwd_a`=`fwd_b`=10.
- **x0 and use flags:**
  - `addi x0` followed by `add x3,x0,x0` → selects 00.
  - `lui x5` followed by an instruction with rs1=5 but `id_use_rs1`=0 → `fwd_a`=00.
- **Load-use:**
  - `lw x5` followed by `add x6,x5,x2` → `stall`=`bubble`=1 for exactly 1 cycle and `stall_cnt` goes 0→1.
  - Next the consumer is in EX with `fwd_a`=01.
- **Flush vs stall:** the same load-use pair with `flush`=1 in the hazard cycle → `stall`=0, `bubble`=1, `stall_cnt` unchanged, and the EX slot is invalid at the next cycle.
- **Reset and saturation:**
  - Assert `rst` during a stall → all outputs 0 the next cycle.
  - With CNT_W=4, hold a hazard 20 cycles → `stall_cnt`=15.
